// File: rtl/period_duty_meter.sv
// period_duty_meter: measures high time, low time and period of a sampled waveform with hysteresis, averaging and a loss-of-signal timeout
// Ports: CLK/RSTB clock and async active-high reset; DATA_IN/DATA_VALID qualified sample stream;
// TRIG/HYST trigger level and hysteresis half-width; HIGH_TIME/LOW_TIME/PERIOD (averaged) results in samples;
// PERIOD_FLAG one-cycle update pulse; TIMEOUT_FLAG sticky loss-of-signal indicator.
module period_duty_meter #(
    parameter int               DATA_W      = 12,
    parameter int               CNT_W       = 25,
    parameter int               AVG_LOG2    = 0,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = 25'd20000000
) (
    input  logic              CLK,
    input  logic              RSTB,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              DATA_VALID,
    input  logic [DATA_W-1:0] TRIG,
    input  logic [DATA_W-1:0] HYST,
    output logic [CNT_W-1:0]  HIGH_TIME,
    output logic [CNT_W-1:0]  LOW_TIME,
    output logic [CNT_W-1:0]  PERIOD,
    output logic              PERIOD_FLAG,
    output logic              TIMEOUT_FLAG
);
    localparam int AW = CNT_W + AVG_LOG2;
    localparam int KW = AVG_LOG2 + 1;
    localparam logic [KW-1:0] K_LAST = KW'(1) << AVG_LOG2;

    typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic [CNT_W-1:0] high_q, high_d, low_q, low_d, per_q, per_d;
    logic [AW-1:0]    acc_h_q, acc_h_d, acc_l_q, acc_l_d;
    logic [KW-1:0]    k_q, k_d;
    logic             flag_q, flag_d, to_q, to_d;
    logic [DATA_W:0]  th_sum;
    logic [DATA_W-1:0] hi_th, lo_th;
    logic             rise, fall, close;
    logic [CNT_W-1:0] h_inc, l_inc;
    logic [AW-1:0]    sum_h, sum_l, sum_p;
    logic [KW-1:0]    k_inc;
    logic [CNT_W:0]   tot;

    always_comb begin
        th_sum  = {1'b0, TRIG} + {1'b0, HYST};
        hi_th   = th_sum[DATA_W] ? '1 : th_sum[DATA_W-1:0];
        lo_th   = (TRIG > HYST) ? TRIG - HYST : '0;
        rise    = DATA_IN >= hi_th;
        fall    = DATA_IN < lo_th;
        h_inc   = (&hcnt_q) ? hcnt_q : hcnt_q + CNT_W'(1);
        l_inc   = (&lcnt_q) ? lcnt_q : lcnt_q + CNT_W'(1);
        sum_h   = acc_h_q + AW'(hcnt_q);
        sum_l   = acc_l_q + AW'(lcnt_q);
        sum_p   = sum_h + sum_l;
        k_inc   = k_q + KW'(1);
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        high_d  = high_q;
        low_d   = low_q;
        per_d   = per_q;
        acc_h_d = acc_h_q;
        acc_l_d = acc_l_q;
        k_d     = k_q;
        flag_d  = 1'b0;
        to_d    = to_q;
        close   = 1'b0;
        tot     = '0;
        if (DATA_VALID) begin
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_d = ARMED;
                        lcnt_d  = '0;
                    end
                end
                // While ARMED, lcnt counts samples waiting for the first rise so
                // the timeout check below covers this state too.
                ARMED: begin
                    if (rise) begin
                        state_d = HIGH;
                        hcnt_d  = CNT_W'(1);
                        lcnt_d  = '0;
                    end else begin
                        lcnt_d = l_inc;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        lcnt_d  = CNT_W'(1);
                    end else begin
                        hcnt_d = h_inc;
                    end
                end
                LOW: begin
                    if (rise) begin
                        close   = 1'b1;
                        state_d = HIGH;
                        hcnt_d  = CNT_W'(1);
                        lcnt_d  = '0;
                    end else begin
                        lcnt_d = l_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
            tot = {1'b0, hcnt_d} + {1'b0, lcnt_d};
            // A close on the same sample wins over the timeout.
            if (close) begin
                if (k_inc == K_LAST) begin
                    high_d  = sum_h[AVG_LOG2 +: CNT_W];
                    low_d   = sum_l[AVG_LOG2 +: CNT_W];
                    per_d   = sum_p[AVG_LOG2 +: CNT_W];
                    flag_d  = 1'b1;
                    to_d    = 1'b0;
                    acc_h_d = '0;
                    acc_l_d = '0;
                    k_d     = '0;
                end else begin
                    acc_h_d = sum_h;
                    acc_l_d = sum_l;
                    k_d     = k_inc;
                end
            end else if (state_q != IDLE && tot >= {1'b0, TIMEOUT_CYC}) begin
                state_d = IDLE;
                hcnt_d  = '0;
                lcnt_d  = '0;
                acc_h_d = '0;
                acc_l_d = '0;
                k_d     = '0;
                to_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            high_q  <= '0;
            low_q   <= '0;
            per_q   <= '0;
            acc_h_q <= '0;
            acc_l_q <= '0;
            k_q     <= '0;
            flag_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            high_q  <= high_d;
            low_q   <= low_d;
            per_q   <= per_d;
            acc_h_q <= acc_h_d;
            acc_l_q <= acc_l_d;
            k_q     <= k_d;
            flag_q  <= flag_d;
            to_q    <= to_d;
        end
    end

    assign HIGH_TIME    = high_q;
    assign LOW_TIME     = low_q;
    assign PERIOD       = per_q;
    assign PERIOD_FLAG  = flag_q;
    assign TIMEOUT_FLAG = to_q;
endmodule

// File: tb/tb_period_duty_meter.sv
// tb_period_duty_meter: self-checking bench for period_duty_meter
module tb_period_duty_meter;
    typedef struct {
        int trig, hyst;
        int hi_lvl, hi_n, band_h;
        int lo_lvl, lo_n, band_l;
        int band_a, band_b;
        int exp_h, exp_l, exp_p;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RSTB = 1'b1;
    logic        DATA_VALID = 1'b0;
    logic [11:0] DATA_IN = '0;
    logic [11:0] TRIG = 12'd10;
    logic [11:0] HYST = '0;
    logic [24:0] h0, l0, p0, h2, l2, p2;
    logic        f0, t0, f2, t2;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int fc0 = 0, last0 = 0, gap0 = 0;
    vec_t vecs[6];

    period_duty_meter #(.AVG_LOG2(0), .TIMEOUT_CYC(25'd100)) dut0 (
        .CLK(CLK), .RSTB(RSTB), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .TRIG(TRIG), .HYST(HYST), .HIGH_TIME(h0), .LOW_TIME(l0), .PERIOD(p0),
        .PERIOD_FLAG(f0), .TIMEOUT_FLAG(t0));

    period_duty_meter #(.AVG_LOG2(2), .TIMEOUT_CYC(25'd100)) dut2 (
        .CLK(CLK), .RSTB(RSTB), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .TRIG(TRIG), .HYST(HYST), .HIGH_TIME(h2), .LOW_TIME(l2), .PERIOD(p2),
        .PERIOD_FLAG(f2), .TIMEOUT_FLAG(t2));

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (f0) begin
            fc0   <= fc0 + 1;
            gap0  <= cyc - last0;
            last0 <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out0(input string nm, input int f, input int h, input int l, input int p);
        chk({nm, "_flag"}, 64'(f0), 64'(f));
        chk({nm, "_high"}, 64'(h0), 64'(h));
        chk({nm, "_low"}, 64'(l0), 64'(l));
        chk({nm, "_period"}, 64'(p0), 64'(p));
    endtask

    task automatic chk_out2(input string nm, input int f, input int h, input int l, input int p);
        chk({nm, "_flag2"}, 64'(f2), 64'(f));
        chk({nm, "_high2"}, 64'(h2), 64'(h));
        chk({nm, "_low2"}, 64'(l2), 64'(l));
        chk({nm, "_period2"}, 64'(p2), 64'(p));
    endtask

    task automatic smp(input int d);
        DATA_IN = 12'(d);
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Invalid cycle carrying the opposite level, then the real sample.
    task automatic gsmp(input int d);
        DATA_IN = (d >= 10) ? 12'd2 : 12'd12;
        DATA_VALID = 1'b0;
        @(posedge CLK);
        #1;
        smp(d);
    endtask

    task automatic rst_pulse;
        RSTB = 1'b1;
        DATA_VALID = 1'b0;
        @(posedge CLK);
        #1;
        RSTB = 1'b0;
    endtask

    initial begin
        int s;
        int avg[8];
        vecs[0] = '{10, 0, 12, 6, 0, 2, 6, 0, 9, 11, 6, 6, 12};
        vecs[1] = '{10, 0, 12, 6, 0, 2, 6, 0, 9, 11, 6, 6, 12};
        vecs[2] = '{10, 2, 12, 4, 4, 6, 6, 2, 9, 11, 8, 8, 16};
        vecs[3] = '{10, 0, 12, 3, 0, 2, 9, 0, 9, 11, 3, 9, 12};
        vecs[4] = '{100, 50, 200, 5, 0, 0, 2, 0, 9, 11, 5, 2, 7};
        vecs[5] = '{4000, 200, 4095, 2, 0, 0, 3, 2, 3900, 3900, 2, 5, 7};
        avg = '{5, 5, 7, 5, 5, 7, 7, 7};

        #12;
        chk_out0("reset", 0, 0, 0, 0);
        chk("reset_timeout", 64'(t0), 64'd0);
        @(posedge CLK);
        #1;
        RSTB = 1'b0;

        TRIG = 12'd10;
        HYST = 12'd0;
        smp(2);
        for (int i = 0; i < 6; i++) begin
            TRIG = 12'(vecs[i].trig);
            HYST = 12'(vecs[i].hyst);
            for (int j = 0; j < vecs[i].hi_n; j++) begin
                smp(vecs[i].hi_lvl);
                if (j == 0 && i == 0) chk("arm_rise_flag", 64'(f0), 64'd0);
                if (j == 0 && i > 0)
                    chk_out0($sformatf("vec%0d", i - 1), 1, vecs[i-1].exp_h, vecs[i-1].exp_l, vecs[i-1].exp_p);
                if (j == 1) chk($sformatf("vec%0d_pulse", i), 64'(f0), 64'd0);
                if (j == 1 && i == 2) chk("flag_gap_12", 64'(gap0), 64'd12);
            end
            for (int b = 0; b < vecs[i].band_h; b++) smp(b % 2 == 0 ? vecs[i].band_a : vecs[i].band_b);
            for (int j = 0; j < vecs[i].lo_n; j++) smp(vecs[i].lo_lvl);
            for (int b = 0; b < vecs[i].band_l; b++) smp(b % 2 == 0 ? vecs[i].band_a : vecs[i].band_b);
        end
        smp(vecs[5].hi_lvl);
        chk_out0("vec5", 1, vecs[5].exp_h, vecs[5].exp_l, vecs[5].exp_p);

        rst_pulse();
        TRIG = 12'd10;
        HYST = 12'd0;
        s = fc0;
        gsmp(2);
        repeat (6) gsmp(12);
        repeat (6) gsmp(2);
        gsmp(12);
        chk_out0("gapped1", 1, 6, 6, 12);
        repeat (5) gsmp(12);
        chk("gapped_pulse", 64'(f0), 64'd0);
        repeat (6) gsmp(2);
        gsmp(12);
        chk_out0("gapped2", 1, 6, 6, 12);
        DATA_VALID = 1'b0;
        @(posedge CLK);
        #1;
        chk("gapped_gap_24", 64'(gap0), 64'd24);
        chk("gapped_count", 64'(fc0 - s), 64'd2);

        rst_pulse();
        smp(2);
        repeat (6) smp(12);
        repeat (6) smp(2);
        smp(12);
        chk_out0("to_pre", 1, 6, 6, 12);
        repeat (98) smp(12);
        chk("to_not_yet", 64'(t0), 64'd0);
        smp(12);
        chk("to_set", 64'(t0), 64'd1);
        chk_out0("to_hold", 0, 6, 6, 12);
        smp(12);
        chk("to_sticky", 64'(t0), 64'd1);
        repeat (5) smp(2);
        repeat (4) smp(12);
        repeat (5) smp(2);
        chk("to_still", 64'(t0), 64'd1);
        chk("to_hold_high", 64'(h0), 64'd6);
        smp(12);
        chk_out0("to_recover", 1, 4, 5, 9);
        chk("to_cleared", 64'(t0), 64'd0);

        rst_pulse();
        smp(2);
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < avg[2*j]; k++) begin
                smp(12);
                if (k == 0 && j > 0) chk($sformatf("avg_noflag%0d", j), 64'(f2), 64'd0);
            end
            repeat (avg[2*j+1]) smp(2);
        end
        smp(12);
        chk_out2("avg", 1, 6, 6, 12);
        chk_out0("avg_last", 1, 7, 7, 14);

        smp(12);
        smp(12);
        #2;
        RSTB = 1'b1;
        #1;
        chk_out0("midrst", 0, 0, 0, 0);
        chk("midrst_high2", 64'(h2), 64'd0);
        #1;
        RSTB = 1'b0;
        s = fc0;
        repeat (3) smp(12);
        repeat (6) smp(2);
        repeat (6) smp(12);
        repeat (6) smp(2);
        chk("midrst_noflag", 64'(fc0 - s), 64'd0);
        smp(12);
        chk_out0("midrst_first", 1, 6, 6, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/period_duty_meter.md
Name: period_duty_meter

Overview:
- Measures high time, low time and period of a sampled waveform at a programmable trigger level, with hysteresis.
- Optionally averages over 2^AVG_LOG2 periods.
- Flags loss of signal via a timeout.
- Sits after the ADC sample stream in the computation path and feeds the frequency/duty readout, alongside the existing time measurement logic.

Parameters:
- DATA_W, 12, sample and trigger width
- CNT_W, 25, width of time counters and outputs (units: valid samples)
- AVG_LOG2, 0, log2 of number of periods averaged per output update (0 = every period)
- TIMEOUT_CYC, 25'd20000000, sample count without a completed period before timeout

Ports:
- CLK  in  1  system clock, rising edge
- RSTB  in  1  asynchronous active-high reset
- DATA_IN  in  DATA_W  unsigned sample
- DATA_VALID  in  1  sample qualifier; all state holds when low
- TRIG  in  DATA_W  trigger level, sampled every cycle
- HYST  in  DATA_W  hysteresis half-width
- HIGH_TIME  out  CNT_W  (averaged) samples at/above threshold per period
- LOW_TIME  out  CNT_W  (averaged) samples below threshold per period
- PERIOD  out  CNT_W  (averaged) HIGH_TIME+LOW_TIME, computed from the same accumulators
- PERIOD_FLAG  out  1  one-cycle pulse when outputs update
- TIMEOUT_FLAG  out  1  sticky loss-of-signal indicator

Behaviour:
- Reset: asynchronous, active-high; clock CLK, reset RSTB. All outputs 0, state IDLE, counters and accumulators 0.
- Thresholds, combinational:
  - hi_th = min(TRIG+HYST, 2^DATA_W-1), saturating.
  - lo_th = (TRIG>HYST) ? TRIG-HYST : 0.
  - rise = DATA_IN >= hi_th.
  - fall = DATA_IN < lo_th.
  - With lo_th=0, fall never occurs (timeout follows).
- States, evaluated only on DATA_VALID=1:
  - IDLE: fall -> ARMED. Otherwise stay. Ensures the first measurement starts on a genuine rising crossing.
  - ARMED: rise -> HIGH, hcnt=1, lcnt=0. Otherwise stay.
  - HIGH: fall -> LOW, lcnt=1. Otherwise hcnt++.
  - LOW: rise closes the period. Capture (hcnt, lcnt), then hcnt=1, lcnt=0, -> HIGH. Otherwise lcnt++.
- Between thresholds (hysteresis band), the sample counts toward the current level.
- hcnt and lcnt saturate at 2^CNT_W-1.
- Period close:
  - acc_h += hcnt, acc_l += lcnt, k++. Accumulators are CNT_W+AVG_LOG2 wide.
  - When k reaches 2^AVG_LOG2:
    - HIGH_TIME = acc_h>>AVG_LOG2, LOW_TIME = acc_l>>AVG_LOG2, PERIOD = (acc_h+acc_l)>>AVG_LOG2, truncating.
    - PERIOD_FLAG=1 for one cycle.
    - Accumulators and k cleared.
    - TIMEOUT_FLAG cleared.
  - Outputs are registered and appear the cycle after the closing sample's clock edge. Latency is 1 clock from the closing sample.
- Outputs hold their last values between updates and through timeouts.
- Timeout:
  - In ARMED, HIGH or LOW, a sample on which hcnt+lcnt (or samples since entering ARMED) would reach TIMEOUT_CYC without a close -> IDLE.
  - TIMEOUT_FLAG=1; hcnt, lcnt, accumulators and k cleared.
  - A period close on the same sample takes priority over the timeout.
- TRIG/HYST changes mid-period apply from the next sample; no restart.
- DATA_VALID=0: no counting, no transitions, PERIOD_FLAG stays 0.
- RSTB asserted mid-period: immediate return to reset values. No flag pulse for the partial period.

Test Plan:
- TRIG=10, HYST=0, AVG_LOG2=0, DATA_VALID=1. Square wave 6 samples at 12, 6 samples at 2, starting low -> first PERIOD_FLAG one cycle after the second rising sample. HIGH_TIME=6, LOW_TIME=6, PERIOD=12. Flag repeats every 12 cycles.
- Same wave, DATA_VALID high every other cycle -> identical values (6/6/12). Flag every 24 clocks.
- TRIG=10, HYST=2. Signal dithers 9,11,9,11 between clean periods -> no spurious close. HIGH_TIME/LOW_TIME match the clean 12/8 levels only.
- AVG_LOG2=2. Periods with high/low = (5,5), (7,5), (5,7), (7,7) -> one flag after the fourth close. HIGH_TIME=6, LOW_TIME=6, PERIOD=12. No flag after closes 1-3.
- TIMEOUT_CYC=100, DC input 12 after one rising crossing -> TIMEOUT_FLAG=1 at sample 100, state IDLE, previous outputs held. Restoring the square wave -> flag clears on the next update.
- RSTB pulsed mid-period of the 6/6 wave -> outputs 0 immediately. The first update comes after the wave has passed through a low sample, then two rising crossings.
